// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: M-op codes, sequencer state
// encoding and operand-signedness helpers.
package mdu_pkg;

   localparam logic [2:0] MD_MUL    = 3'd0;
   localparam logic [2:0] MD_MULH   = 3'd1;
   localparam logic [2:0] MD_MULHSU = 3'd2;
   localparam logic [2:0] MD_MULHU  = 3'd3;
   localparam logic [2:0] MD_DIV    = 3'd4;
   localparam logic [2:0] MD_DIVU   = 3'd5;
   localparam logic [2:0] MD_REM    = 3'd6;
   localparam logic [2:0] MD_REMU   = 3'd7;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_FIX  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   function automatic logic is_div(input logic [2:0] code);
      return code[2];
   endfunction

   function automatic logic a_signed(input logic [2:0] code);
      return (code == MD_MULH) || (code == MD_MULHSU) || (code == MD_DIV) || (code == MD_REM);
   endfunction

   function automatic logic b_signed(input logic [2:0] code);
      return (code == MD_MULH) || (code == MD_DIV) || (code == MD_REM);
   endfunction

endpackage

// File: rtl/mdu_iter_step.sv
// One iteration of the shared datapath: shift-add multiply step or restoring-divide step
// on the {hi, lo} working register against a magnitude operand.
module mdu_iter_step #(
   parameter int unsigned XLEN = 32
) (
   input  logic            is_div_i,
   input  logic [XLEN-1:0] hi_i,
   input  logic [XLEN-1:0] lo_i,
   input  logic [XLEN-1:0] opnd_i,
   output logic [XLEN-1:0] hi_o,
   output logic [XLEN-1:0] lo_o
);

   logic [XLEN:0] sum;
   logic [XLEN:0] shifted;
   logic          fits;

   always_comb begin
      sum     = {1'b0, hi_i} + (lo_i[0] ? {1'b0, opnd_i} : '0);
      shifted = {hi_i, lo_i[XLEN-1]};
      fits    = (shifted >= {1'b0, opnd_i});
      if (is_div_i) begin
         // Partial remainder always fits XLEN bits after a successful trial subtract.
         hi_o = fits ? XLEN'(shifted - {1'b0, opnd_i}) : shifted[XLEN-1:0];
         lo_o = {lo_i[XLEN-2:0], fits};
      end else begin
         hi_o = sum[XLEN:1];
         lo_o = {sum[0], lo_i[XLEN-1:1]};
      end
   end

endmodule

// File: rtl/mdu_seq_ctrl.sv
// Sequencer for the shared RV32M multiply/divide unit: owns the FSM, iteration counter,
// operand magnitudes, sign fix-up and the held result, and stalls the front of the pipe.
module mdu_seq_ctrl
   import mdu_pkg::*;
#(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned CNT_W = 5
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start_i,
   input  logic [2:0]      MDCode_i,
   input  logic [XLEN-1:0] A_i,
   input  logic [XLEN-1:0] B_i,
   input  logic            flush_i,
   output logic            stall_o,
   output logic            done_o,
   output logic [XLEN-1:0] result_o
);

   localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};

   logic [1:0]      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d, result_q, result_d;
   logic [2:0]      code_q, code_d;
   logic            neg_q, neg_d, aneg_q, aneg_d;

   logic [XLEN-1:0]   hi_step, lo_step;
   logic [XLEN-1:0]   abs_a, abs_b, quot_fix, rem_fix;
   logic [2*XLEN-1:0] prod_fix;
   logic              a_neg_in, b_neg_in, accept;

   mdu_iter_step #(
      .XLEN(XLEN)
   ) u_step (
      .is_div_i(is_div(code_q)),
      .hi_i    (hi_q),
      .lo_i    (lo_q),
      .opnd_i  (opnd_q),
      .hi_o    (hi_step),
      .lo_o    (lo_step)
   );

   always_comb begin
      a_neg_in = a_signed(MDCode_i) && A_i[XLEN-1];
      b_neg_in = b_signed(MDCode_i) && B_i[XLEN-1];
      abs_a    = a_neg_in ? -A_i : A_i;
      abs_b    = b_neg_in ? -B_i : B_i;
      accept   = (state_q == S_IDLE) && start_i && !flush_i;

      prod_fix = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
      quot_fix = neg_q ? -lo_q : lo_q;
      rem_fix  = aneg_q ? -hi_q : hi_q;

      state_d  = state_q;
      cnt_d    = cnt_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      opnd_d   = opnd_q;
      code_d   = code_q;
      neg_d    = neg_q;
      aneg_d   = aneg_q;
      result_d = result_q;

      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               code_d = MDCode_i;
               cnt_d  = '0;
               opnd_d = abs_b;
               aneg_d = a_neg_in;
               neg_d  = a_neg_in ^ b_neg_in;
               hi_d   = '0;
               lo_d   = abs_a;
               if (is_div(MDCode_i) && (B_i == '0)) begin
                  result_d = MDCode_i[1] ? A_i : '1;
                  state_d  = S_DONE;
               end else if (((MDCode_i == MD_DIV) || (MDCode_i == MD_REM)) &&
                            (A_i == MinNeg) && (B_i == '1)) begin
                  result_d = MDCode_i[1] ? '0 : MinNeg;
                  state_d  = S_DONE;
               end else begin
                  state_d = S_RUN;
               end
            end
         end
         S_RUN: begin
            hi_d  = hi_step;
            lo_d  = lo_step;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(XLEN-1)) state_d = S_FIX;
         end
         S_FIX: begin
            unique case (code_q)
               MD_MUL:                    result_d = prod_fix[XLEN-1:0];
               MD_MULH, MD_MULHSU, MD_MULHU: result_d = prod_fix[2*XLEN-1:XLEN];
               MD_DIV, MD_DIVU:           result_d = quot_fix;
               default:                   result_d = rem_fix;
            endcase
            state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase

      // A flush kills the op wherever it is and leaves the last result intact.
      if (flush_i) begin
         state_d  = S_IDLE;
         result_d = result_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         opnd_q   <= '0;
         code_q   <= MD_MUL;
         neg_q    <= 1'b0;
         aneg_q   <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         opnd_q   <= opnd_d;
         code_q   <= code_d;
         neg_q    <= neg_d;
         aneg_q   <= aneg_d;
         result_q <= result_d;
      end
   end

   always_comb begin
      stall_o  = accept || (((state_q == S_RUN) || (state_q == S_FIX)) && !flush_i);
      done_o   = (state_q == S_DONE) && !flush_i;
      result_o = result_q;
   end

endmodule

// File: tb/tb_mdu_seq_ctrl.sv
// Directed bench for mdu_seq_ctrl: vector table of single M-ops plus flush, back-to-back
// and mid-operation reset sequences.
module tb_mdu_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start_i;
   logic [2:0]  MDCode_i;
   logic [31:0] A_i, B_i;
   logic        flush_i;
   logic        stall_o, done_o;
   logic [31:0] result_o;

   int total = 0;
   int bad   = 0;

   mdu_seq_ctrl #(
      .XLEN (32),
      .CNT_W(5)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start_i (start_i),
      .MDCode_i(MDCode_i),
      .A_i     (A_i),
      .B_i     (B_i),
      .flush_i (flush_i),
      .stall_o (stall_o),
      .done_o  (done_o),
      .result_o(result_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [2:0]  code;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Called just after a rising edge; returns latency in cycles from start to done_o.
   task automatic run_op(input logic [2:0] code, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat, output int stalls);
      MDCode_i = code;
      A_i      = a;
      B_i      = b;
      start_i  = 1'b1;
      lat      = -1;
      stalls   = 0;
      res      = '0;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (stall_o) stalls++;
         if (done_o) begin
            lat = c;
            res = result_o;
            break;
         end
         @(posedge clk);
         #1;
      end
      @(posedge clk);
      #1;
      start_i = 1'b0;
   endtask

   vec_t        vecs[$];
   logic [31:0] res;
   int          lat, stalls, dones, n;
   int          dcyc[2];
   logic [31:0] dres[2];

   initial begin
      vecs.push_back('{"mul_7_m3",      3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34});
      vecs.push_back('{"mulhu_ones",    3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 34});
      vecs.push_back('{"mulh_ones",     3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, 34});
      vecs.push_back('{"mulhsu_m1",     3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 34});
      vecs.push_back('{"divu_100_7",    3'd5, 32'd100,        32'd7,         32'd14,        34});
      vecs.push_back('{"remu_100_7",    3'd7, 32'd100,        32'd7,         32'd2,         34});
      vecs.push_back('{"div_m7_2",      3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 34});
      vecs.push_back('{"rem_m7_2",      3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 34});
      vecs.push_back('{"divu_max_1",    3'd5, 32'hFFFF_FFFF,  32'd1,         32'hFFFF_FFFF, 34});
      vecs.push_back('{"div_5_0",       3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF, 1});
      vecs.push_back('{"rem_5_0",       3'd6, 32'd5,          32'd0,         32'd5,         1});
      vecs.push_back('{"remu_5_0",      3'd7, 32'd5,          32'd0,         32'd5,         1});
      vecs.push_back('{"div_ovf",       3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1});
      vecs.push_back('{"rem_ovf",       3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 1});

      rst_n    = 1'b0;
      start_i  = 1'b0;
      flush_i  = 1'b0;
      MDCode_i = '0;
      A_i      = '0;
      B_i      = '0;
      #1;
      check("reset_result", result_o, 32'h0);
      check("reset_done", {31'b0, done_o}, 32'h0);
      check("reset_stall", {31'b0, stall_o}, 32'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      foreach (vecs[i]) begin
         run_op(vecs[i].code, vecs[i].a, vecs[i].b, res, lat, stalls);
         check({vecs[i].name, "_result"}, res, vecs[i].exp);
         check({vecs[i].name, "_latency"}, lat, vecs[i].lat);
         check({vecs[i].name, "_stall_cycles"}, stalls, vecs[i].lat);
      end

      // Flush during RUN (cycle 10): no done, result keeps the previous value (rem_ovf = 0).
      MDCode_i = 3'd0;
      A_i      = 32'd3;
      B_i      = 32'd5;
      start_i  = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk);
         #1;
      end
      flush_i = 1'b1;
      @(negedge clk);
      check("flush_stall_drop", {31'b0, stall_o}, 32'h0);
      check("flush_no_done", {31'b0, done_o}, 32'h0);
      @(posedge clk);
      #1;
      flush_i = 1'b0;
      start_i = 1'b0;
      dones   = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (done_o || stall_o) dones++;
         @(posedge clk);
         #1;
      end
      check("flush_quiet_after", dones, 32'd0);
      check("flush_result_held", result_o, 32'h0);
      run_op(3'd3, 32'h8000_0000, 32'd2, res, lat, stalls);
      check("post_flush_result", res, 32'd1);
      check("post_flush_latency", lat, 32'd34);

      // Back-to-back DIVU then MUL with start_i held high throughout.
      MDCode_i = 3'd5;
      A_i      = 32'd100;
      B_i      = 32'd7;
      start_i  = 1'b1;
      n        = 0;
      dcyc     = '{-1, -1};
      dres     = '{32'h0, 32'h0};
      for (int c = 0; c < 120 && n < 2; c++) begin
         @(negedge clk);
         if (done_o) begin
            dcyc[n] = c;
            dres[n] = result_o;
            n++;
         end
         @(posedge clk);
         #1;
         if (n == 1) begin
            MDCode_i = 3'd0;
            A_i      = 32'd7;
            B_i      = 32'hFFFF_FFFD;
         end
      end
      start_i = 1'b0;
      check("b2b_done_count", n, 32'd2);
      check("b2b_first_result", dres[0], 32'd14);
      check("b2b_second_result", dres[1], 32'hFFFF_FFEB);
      check("b2b_first_cycle", dcyc[0], 32'd34);
      check("b2b_spacing", dcyc[1] - dcyc[0], 32'd35);

      // Asynchronous reset in the middle of RUN.
      @(posedge clk);
      #1;
      MDCode_i = 3'd5;
      A_i      = 32'd1000;
      B_i      = 32'd3;
      start_i  = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      check("pre_reset_stall", {31'b0, stall_o}, 32'h1);
      #2;
      rst_n   = 1'b0;
      start_i = 1'b0;
      #1;
      check("async_reset_result", result_o, 32'h0);
      check("async_reset_stall", {31'b0, stall_o}, 32'h0);
      check("async_reset_done", {31'b0, done_o}, 32'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      run_op(3'd7, 32'd1000, 32'd3, res, lat, stalls);
      check("post_reset_remu", res, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
